// File: rtl/up_bus_initiator.sv
// up_bus_initiator: initiator side of the 8-bit uP handshake bus.
// A local command (addr, wdata, rw) is serialised as five bytes (address, then
// data LSB first) using a four-phase handshake_1/handshake_2 exchange, closed by ack.
// Optional build macro UP_INIT_TIMEOUT_EN bounds every responder wait by TIMEOUT_CYCLES.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// START    | frame opened (up_start), setup gap before first byte
// SETUP    | byte idx on the bus (or bus released for read data), setup gap
// HS1_HI   | handshake_1 high, waiting for handshake_2 high
// HS1_LO   | handshake_1 low, waiting for handshake_2 low
// ACK_WAIT | all bytes transferred, waiting for ack high
// END_ST   | frame closed, waiting for ack low
// DONE     | one-cycle response
module up_bus_initiator #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        up_start,
  output logic        up_rw,
  output logic        up_handshake_1,
  input  logic        up_handshake_2,
  input  logic        up_ack,
  output logic [7:0]  up_data_out,
  output logic        up_data_oe,
  input  logic [7:0]  up_data_in
);

  typedef enum logic [2:0] {
    IDLE, START, SETUP, HS1_HI, HS1_LO, ACK_WAIT, END_ST, DONE
  } state_t;

  localparam logic [15:0] SETUP_LOAD = 16'(SETUP_CYCLES - 1);

  state_t      state, state_next;
  logic        hs2_meta, hs2_sync, ack_meta, ack_sync;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic        rw_q;
  logic [2:0]  idx;
  logic [15:0] setup_cnt;
  logic [7:0]  tx_byte;
  logic        accept, wait_met, drive_byte, to_hit, abort;

  assign accept = cmd_valid && cmd_ready;
  assign abort  = to_hit && !wait_met;

  // Responder strobes are asynchronous: two-flop synchronizers before any use.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs2_meta <= 1'b0;
      hs2_sync <= 1'b0;
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      hs2_meta <= up_handshake_2;
      hs2_sync <= hs2_meta;
      ack_meta <= up_ack;
      ack_sync <= ack_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Setup down-counter reloads on every state change; terminal count at zero.
  always_ff @(posedge clk) begin
    if (reset)                   setup_cnt <= '0;
    else if (state_next != state) setup_cnt <= SETUP_LOAD;
    else if (setup_cnt != 16'd0) setup_cnt <= setup_cnt - 16'd1;
  end

  // Command latch, byte index and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
      idx     <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        rw_q    <= cmd_rw;
        rdata_q <= '0;
      end
      if (state == START)
        idx <= '0;
      else if (state == HS1_LO && state_next == SETUP)
        idx <= idx + 3'd1;
      if (state == HS1_HI && hs2_sync && rw_q) begin
        case (idx)
          3'd1:    rdata_q[7:0]   <= up_data_in;
          3'd2:    rdata_q[15:8]  <= up_data_in;
          3'd3:    rdata_q[23:16] <= up_data_in;
          3'd4:    rdata_q[31:24] <= up_data_in;
          default: ;
        endcase
      end
    end
  end

  // Response data loads when DONE is entered and holds until the next response.
  always_ff @(posedge clk) begin
    if (reset)
      rsp_rdata <= '0;
    else if (state_next == DONE && state != DONE)
      rsp_rdata <= (rw_q && !abort) ? rdata_q : 32'h0;
  end

  // Byte selected by the frame index: address first, then data LSB first.
  always_comb begin
    tx_byte = addr_q;
    case (idx)
      3'd1:    tx_byte = wdata_q[7:0];
      3'd2:    tx_byte = wdata_q[15:8];
      3'd3:    tx_byte = wdata_q[23:16];
      3'd4:    tx_byte = wdata_q[31:24];
      default: tx_byte = addr_q;
    endcase
  end

  // Next-state and pin decode; all pins are pure state decode so reset clears them in one clock.
  always_comb begin
    state_next     = state;
    wait_met       = 1'b0;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    up_start       = 1'b0;
    up_rw          = 1'b0;
    up_handshake_1 = 1'b0;
    up_data_oe     = 1'b0;
    up_data_out    = 8'h00;
    drive_byte     = (idx == 3'd0) || !rw_q;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = START;
      end
      START: begin
        up_start = 1'b1;
        up_rw    = rw_q;
        if (setup_cnt == 16'd0) state_next = SETUP;
      end
      SETUP: begin
        up_start   = 1'b1;
        up_rw      = rw_q;
        up_data_oe = drive_byte;
        if (setup_cnt == 16'd0) state_next = HS1_HI;
      end
      HS1_HI: begin
        up_start       = 1'b1;
        up_rw          = rw_q;
        up_data_oe     = drive_byte;
        up_handshake_1 = 1'b1;
        wait_met       = hs2_sync;
        if (wait_met)    state_next = HS1_LO;
        else if (to_hit) state_next = DONE;
      end
      HS1_LO: begin
        up_start   = 1'b1;
        up_rw      = rw_q;
        up_data_oe = drive_byte;
        wait_met   = !hs2_sync;
        if (wait_met)    state_next = (idx == 3'd4) ? ACK_WAIT : SETUP;
        else if (to_hit) state_next = DONE;
      end
      ACK_WAIT: begin
        up_start = 1'b1;
        up_rw    = rw_q;
        wait_met = ack_sync;
        if (wait_met)    state_next = END_ST;
        else if (to_hit) state_next = DONE;
      end
      END_ST: begin
        wait_met = !ack_sync;
        if (wait_met || to_hit) state_next = DONE;
      end
      DONE: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (up_data_oe) up_data_out = tx_byte;
  end

`ifdef UP_INIT_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
  logic        err_q;
  logic        waiting;

  assign waiting   = (state == HS1_HI) || (state == HS1_LO) ||
                     (state == ACK_WAIT) || (state == END_ST);
  assign to_hit    = waiting && (to_cnt == TO_LAST);
  assign rsp_error = rsp_valid && err_q;

  // Wait-budget counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset)                    to_cnt <= '0;
    else if (state_next != state) to_cnt <= '0;
    else if (waiting)             to_cnt <= to_cnt + 16'd1;
  end

  // Error flag remembers an abort until the next command is accepted.
  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (abort)  err_q <= 1'b1;
  end
`else
  // Without the timeout build the comparison folds to 0; waits are unbounded.
  assign to_hit    = (TIMEOUT_CYCLES < 0);
  assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_up_bus_initiator.sv
// Directed bench for up_bus_initiator with a behavioural bus responder.
`timescale 1ns/1ps
module tb_up_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_rw, cmd_ready;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        up_start, up_rw, up_handshake_1, up_data_oe;
  logic        up_handshake_2, up_ack;
  logic [7:0]  up_data_out, up_data_in;

  int compared   = 0;
  int mismatched = 0;

  always #10 clk = ~clk;

  up_bus_initiator #(.SETUP_CYCLES(2), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .up_start(up_start), .up_rw(up_rw), .up_handshake_1(up_handshake_1),
    .up_handshake_2(up_handshake_2), .up_ack(up_ack),
    .up_data_out(up_data_out), .up_data_oe(up_data_oe), .up_data_in(up_data_in)
  );

  // Responder model: logs each byte at handshake_1 rise, answers after r_dly clocks.
  int         r_st = 0, r_cnt = 0, r_byte = 0, r_dly = 0;
  bit         r_mute = 1'b0;
  logic [7:0] log_b [5];
  logic       log_oe [5];
  logic       log_rw;
  logic [7:0] rd_b [4];
  int         stab_viol = 0;

  always @(posedge clk) begin
    if (reset) begin
      r_st <= 0; r_cnt <= 0; r_byte <= 0;
      up_handshake_2 <= 1'b0; up_ack <= 1'b0; up_data_in <= 8'h00;
    end else begin
      case (r_st)
        0: if (up_handshake_1 && !r_mute) begin
             log_b[r_byte]  <= up_data_out;
             log_oe[r_byte] <= up_data_oe;
             log_rw         <= up_rw;
             if (r_byte > 0) up_data_in <= rd_b[r_byte-1];
             r_cnt <= 0;
             r_st  <= 1;
           end
        1: if (r_cnt >= r_dly) begin up_handshake_2 <= 1'b1; r_st <= 2; end
           else r_cnt <= r_cnt + 1;
        2: if (!up_handshake_1) begin r_cnt <= 0; r_st <= 3; end
           else if (up_data_out !== log_b[r_byte] || up_rw !== log_rw)
             stab_viol <= stab_viol + 1;
        3: if (r_cnt >= r_dly) begin
             up_handshake_2 <= 1'b0;
             if (r_byte == 4) begin r_byte <= 0; r_st <= 4; end
             else begin r_byte <= r_byte + 1; r_st <= 0; end
           end else r_cnt <= r_cnt + 1;
        4: begin up_ack <= 1'b1; r_st <= 5; end
        5: if (!up_start) begin up_ack <= 1'b0; r_st <= 0; end
        default: r_st <= 0;
      endcase
    end
  end

  // Protocol monitor: handshake_1 may only fall after handshake_2 has had time through the synchronizer.
  int   hs2_hi_cnt = 0, early_fall = 0, busy_ready = 0, rsp_cnt = 0;
  logic hs1_prev = 1'b0;

  always @(negedge clk) begin
    hs1_prev   <= up_handshake_1;
    hs2_hi_cnt <= (up_handshake_2 === 1'b1) ? hs2_hi_cnt + 1 : 0;
    if (!reset && hs1_prev && !up_handshake_1 && hs2_hi_cnt < 3) early_fall <= early_fall + 1;
    if (up_start && cmd_ready) busy_ready <= busy_ready + 1;
    if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic rw, input logic [7:0] a, input logic [31:0] d);
    int n;
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("accept_bound", 32'(n < 200), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    check("rsp_bound", 32'(n < 20000), 32'd1);
    rd = rsp_rdata;
    er = rsp_error;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          base, n;

    reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rd_b = '{8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_pins", {27'd0, up_start, up_rw, up_handshake_1, up_data_oe, rsp_valid}, 32'd0);
    check("rst_data_out", 32'(up_data_out), 32'd0);
    check("rst_rsp", {rsp_rdata[30:0], rsp_error}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x12 <- 0xA1B2C3D4
    send(1'b0, 8'h12, 32'hA1B2C3D4);
    wait_rsp(rd, er);
    check("wr_rdata", rd, 32'h0);
    check("wr_error", 32'(er), 32'd0);
    check("wr_bytes0_3", {log_b[0], log_b[1], log_b[2], log_b[3]}, 32'h12D4C3B2);
    check("wr_byte4", 32'(log_b[4]), 32'hA1);
    check("wr_rw", 32'(log_rw), 32'd0);
    check("wr_oe", {27'd0, log_oe[0], log_oe[1], log_oe[2], log_oe[3], log_oe[4]}, 32'h1F);
    repeat (2) @(negedge clk);
    check("wr_rsp_count", 32'(rsp_cnt), 32'd1);

    // Read 0x05, responder returns 11 22 33 44
    rd_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(1'b1, 8'h05, 32'hFFFF_FFFF);
    wait_rsp(rd, er);
    check("rd_rdata", rd, 32'h44332211);
    check("rd_error", 32'(er), 32'd0);
    check("rd_addr", 32'(log_b[0]), 32'h05);
    check("rd_rw", 32'(log_rw), 32'd1);
    check("rd_oe", {27'd0, log_oe[0], log_oe[1], log_oe[2], log_oe[3], log_oe[4]}, 32'h10);

    // Slow responder, 37 clocks per handshake_2 edge
    r_dly = 37;
    rd_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send(1'b1, 8'h33, 32'h0);
    wait_rsp(rd, er);
    check("slow_rdata", rd, 32'hDDCCBBAA);
    check("slow_addr", 32'(log_b[0]), 32'h33);
    r_dly = 0;
    repeat (5) @(negedge clk);
    check("rdata_hold", rsp_rdata, 32'hDDCCBBAA);
    check("early_hs1_fall", 32'(early_fall), 32'd0);
    check("data_stability", 32'(stab_viol), 32'd0);

    // Back-to-back: cmd_valid held high across two commands
    base = rsp_cnt;
    rd_b = '{8'h55, 8'h66, 8'h77, 8'h88};
    cmd_rw = 1'b0; cmd_addr = 8'h40; cmd_wdata = 32'hDEADBEEF; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_rw = 1'b1; cmd_addr = 8'h77; cmd_wdata = 32'h0;
    check("b2b_ready_low", 32'(cmd_ready), 32'd0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    check("b2b_first_rsp", 32'(n < 20000), 32'd1);
    check("b2b_first_rdata", rsp_rdata, 32'h0);
    check("b2b_ready_in_done", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("b2b_ready_after", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(rd, er);
    check("b2b_second_rdata", rd, 32'h88776655);
    check("b2b_second_addr", 32'(log_b[0]), 32'h77);
    repeat (2) @(negedge clk);
    check("b2b_rsp_count", 32'(rsp_cnt - base), 32'd2);
    check("busy_ready", 32'(busy_ready), 32'd0);

    // Reset during byte 2 of a write
    base = rsp_cnt;
    send(1'b0, 8'h5A, 32'h0BADF00D);
    n = 0;
    while (!(r_byte == 2 && up_handshake_1 === 1'b1) && n < 500) begin @(negedge clk); n++; end
    check("rst_mid_reached", 32'(n < 500), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_pins", {27'd0, up_start, up_rw, up_handshake_1, up_data_oe, rsp_valid}, 32'd0);
    check("rst_mid_data", 32'(up_data_out), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_cnt - base), 32'd0);
    send(1'b0, 8'h99, 32'h01020304);
    wait_rsp(rd, er);
    check("post_rst_bytes0_3", {log_b[0], log_b[1], log_b[2], log_b[3]}, 32'h99040302);
    check("post_rst_byte4", 32'(log_b[4]), 32'h01);
    check("post_rst_error", 32'(er), 32'd0);
    check("final_early_fall", 32'(early_fall), 32'd0);

`ifdef UP_INIT_TIMEOUT_EN
    // Silent responder: abort after 50 clocks of handshake_1 high
    r_mute = 1'b1;
    send(1'b0, 8'h21, 32'h1);
    n = 0;
    while (up_handshake_1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (up_handshake_1 === 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("to_hs1_cycles", 32'(n), 32'd50);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_error", 32'(rsp_error), 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    check("to_start_low", 32'(up_start), 32'd0);
    @(negedge clk);
    check("to_after", {29'd0, up_start, rsp_valid, cmd_ready}, 32'd1);
    r_mute = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
